// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter feeding a one-entry output register.
// The winner of a tie alternates; per-source transfer counters wrap.
module mux2_rr_arbiter #(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [N-1:0]  a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [N-1:0]  b_data,
  output logic          b_ready,
  output logic          out_valid,
  output logic [N-1:0]  out_data,
  input  logic          out_ready,
  output logic          sel,
  output logic [CW-1:0] cnt_a,
  output logic [CW-1:0] cnt_b
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic          sel_q, sel_d;
  logic          prio_q, prio_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d;
  logic [CW-1:0] cnt_b_q, cnt_b_d;

  logic can_load, grant_a, grant_b, xfer_a, xfer_b;

  always_comb begin
    can_load = (state_q == EMPTY) || out_ready;
    // prio only matters on a tie; a lone requester always wins
    grant_a  = a_valid && (!b_valid || !prio_q);
    grant_b  = b_valid && (!a_valid ||  prio_q);
    a_ready  = can_load && grant_a;
    b_ready  = can_load && grant_b;
    xfer_a   = a_valid && a_ready;
    xfer_b   = b_valid && b_ready;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    prio_d  = prio_q;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (xfer_a) begin
      state_d = FULL;
      data_d  = a_data;
      sel_d   = 1'b0;
      prio_d  = 1'b1;
      cnt_a_d = cnt_a_q + CW'(1);
    end else if (xfer_b) begin
      state_d = FULL;
      data_d  = b_data;
      sel_d   = 1'b1;
      prio_d  = 1'b0;
      cnt_b_d = cnt_b_q + CW'(1);
    end else if (state_q == FULL && out_ready) begin
      // drain without refill: data and sel keep their last value
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 1'b0;
      prio_q  <= 1'b0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      prio_q  <= prio_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign sel       = sel_q;
  assign cnt_a     = cnt_a_q;
  assign cnt_b     = cnt_b_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench: accepted words are queued with their source and checked
// when they appear on / drain from the output register.
module tb_mux2_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst, a_valid, b_valid, out_ready;
  logic [7:0]  a_data, b_data;
  logic        a_ready, b_ready, out_valid, sel;
  logic [7:0]  out_data;
  logic [15:0] cnt_a, cnt_b;
  // narrow-counter copy sharing the same stimulus
  logic        a_ready4, b_ready4, out_valid4, sel4;
  logic [7:0]  out_data4;
  logic [3:0]  cnt_a4, cnt_b4;

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.N(8), .CW(16)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .sel(sel), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  mux2_rr_arbiter #(.N(8), .CW(4)) dut4 (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready4),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready4),
    .out_valid(out_valid4), .out_data(out_data4), .out_ready(out_ready),
    .sel(sel4), .cnt_a(cnt_a4), .cnt_b(cnt_b4)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0]  sb[$];     // {sel, data}
  logic        ov_m, prio_m, ea, eb, a_acc, b_acc;
  logic [15:0] ca_m, cb_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic step();
    logic can_load;
    #4;
    ea = 1'b0; eb = 1'b0;
    if (!rst) begin
      can_load = !ov_m || out_ready;
      ea = can_load && a_valid && (!b_valid || !prio_m);
      eb = can_load && b_valid && (!a_valid ||  prio_m);
      chk("a_ready", a_ready, ea);
      chk("b_ready", b_ready, eb);
      if (ov_m && out_ready && sb.size() > 0) begin
        logic [8:0] e;
        e = sb.pop_front();
        chk("drain_data", out_data, e[7:0]);
        chk("drain_sel", sel, e[8]);
      end
      if (ea) sb.push_back({1'b0, a_data});
      if (eb) sb.push_back({1'b1, b_data});
    end
    a_acc = ea; b_acc = eb;
    @(posedge clk); #1;
    if (rst) begin
      ov_m = 1'b0; prio_m = 1'b0; ca_m = '0; cb_m = '0;
      sb.delete();
    end else if (ea) begin
      ov_m = 1'b1; prio_m = 1'b1; ca_m++;
    end else if (eb) begin
      ov_m = 1'b1; prio_m = 1'b0; cb_m++;
    end else if (ov_m && out_ready) begin
      ov_m = 1'b0;
    end
    chk("out_valid", out_valid, ov_m);
    chk("cnt_a", cnt_a, ca_m);
    chk("cnt_b", cnt_b, cb_m);
    chk("cnt_a4", cnt_a4, ca_m[3:0]);
    if (ov_m && sb.size() > 0) begin
      chk("head_data", out_data, sb[0][7:0]);
      chk("head_sel", sel, sb[0][8]);
    end
  endtask

  task automatic drive(input logic av, input logic [7:0] ad,
                       input logic bv, input logic [7:0] bd, input logic ordy);
    a_valid = av; a_data = ad; b_valid = bv; b_data = bd; out_ready = ordy;
  endtask

  initial begin
    rst = 1'b1; ov_m = 1'b0; prio_m = 1'b0; ca_m = '0; cb_m = '0;
    drive(0, 8'h00, 0, 8'h00, 0);
    @(posedge clk); #1;
    step();
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_sel", sel, 1'b0);
    rst = 1'b0;

    // alternating tie
    drive(1, 8'hAA, 1, 8'h55, 1);
    step();
    chk("alt_first_data", out_data, 8'hAA);
    chk("alt_first_sel", sel, 1'b0);
    step();
    chk("alt_second_data", out_data, 8'h55);
    chk("alt_second_sel", sel, 1'b1);
    repeat (4) step();
    chk("alt_equal_counts", cnt_a, cnt_b);

    // only B streams at full rate
    drive(0, 8'h00, 1, 8'h0F, 1);
    repeat (4) step();

    // load F0 via A, then stall with both valid
    drive(1, 8'hF0, 0, 8'h00, 1);
    step();
    drive(1, 8'hAA, 1, 8'h55, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold", out_data, 8'hF0);
    end
    out_ready = 1'b1;
    step();
    chk("stall_release_sel", sel, 1'b1);
    drive(0, 8'h00, 0, 8'h00, 1);
    repeat (2) step();

    // single A word then idle
    drive(1, 8'h3C, 0, 8'h00, 1);
    step();
    drive(0, 8'h00, 0, 8'h00, 1);
    step();
    chk("single_drained_valid", out_valid, 1'b0);
    chk("single_retain", out_data, 8'h3C);
    step();

    // narrow counter wrap
    rst = 1'b1; step(); rst = 1'b0;
    drive(1, 8'h11, 0, 8'h00, 1);
    repeat (15) step();
    chk("wrap_15", cnt_a4, 4'd15);
    step();
    chk("wrap_0", cnt_a4, 4'd0);

    // reset while FULL with B's word
    drive(0, 8'h00, 1, 8'h55, 1);
    step();
    drive(1, 8'hAA, 1, 8'h66, 0);
    chk("pre_rst_sel", sel, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("post_rst_data", out_data, 8'h00);
    chk("post_rst_sel", sel, 1'b0);
    out_ready = 1'b1;
    #4;
    chk("post_rst_tie_a", a_ready, 1'b1);
    chk("post_rst_tie_b", b_ready, 1'b0);
    #1; @(posedge clk); #1;
    // that cycle's A acceptance was not modelled; resync with a reset
    rst = 1'b1; step(); rst = 1'b0;

    // random traffic obeying the hold-until-accepted rule
    a_acc = 1'b1; b_acc = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (!a_valid || a_acc) begin a_valid = $urandom_range(0, 1); a_data = 8'($urandom); end
      if (!b_valid || b_acc) begin b_valid = $urandom_range(0, 1); b_data = 8'($urandom); end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
